regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Writer side of the core's 32x32 register file.
- Merges two result sources onto the register file's single write port (we/rd/data):
  - the single-cycle ALU path, which is never stalled;
  - a slow path (loads / multi-cycle units) buffered in a small FIFO.
- Keeps write ordering correct and exports a pending-destination mask for hazard logic.

Parameters:
- XLEN, 32, data width of results and of the write port
- DEPTH, 4, slow-path FIFO entries (power of two, >= 2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- alu_valid  in  1  ALU result valid this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- slow_valid  in  1  slow-path result offered
- slow_ready  out  1  FIFO can accept; transfer when slow_valid && slow_ready
- slow_rd  in  5  slow-path destination register
- slow_data  in  XLEN  slow-path result
- wb_we  out  1  register file write enable (registered)
- wb_rd  out  5  register file write address (registered)
- wb_data  out  XLEN  register file write data (registered)
- pend_mask  out  32  bit k = 1 while a live FIFO entry targets xk
- fifo_count  out  clog2(DEPTH)+1  live + squashed entries held

Behaviour:
- Reset (rst=0, asynchronous):
  - wb_we=0, wb_rd=0, wb_data=0.
  - FIFO emptied, pointers=0, fifo_count=0, pend_mask=0, slow_ready=1.
  - Reset mid-stream discards all buffered entries; nothing is written afterwards.
- x0 handling: writes to x0 are dropped at the source.
  - alu_rd==0 is treated as an idle ALU slot.
  - A slow transfer with slow_rd==0 is accepted (handshake completes) but not enqueued.
- slow_ready = (fifo_count < DEPTH), taken from registered state only; no same-cycle pass-through when full.
- Enqueue: on an accepted transfer, {rd, data, live=1} is written at the tail pointer; the pointer wraps modulo DEPTH.
- ALU priority: if alu_valid && alu_rd!=0, the next edge loads wb_we=1, wb_rd=alu_rd, wb_data=alu_data. ALU latency is exactly 1 cycle.
- Drain: on any cycle with no effective ALU write and the FIFO non-empty, the head is popped.
  - Head live: the next edge loads wb_we=1 with the head's rd/data.
  - Head squashed: popped with wb_we=0 (one bubble per squashed entry).
- Otherwise the next edge loads wb_we=0; wb_rd and wb_data hold their previous values.
- Minimum slow latency: accepted at edge N, written on the port at edge N+1 if the ALU is idle in cycle N+1.
- Order squash:
  - An effective ALU write to rd=r clears the live bit of every entry already in the FIFO with rd==r; those older results must never overwrite the newer ALU value.
  - An entry enqueued on the same edge as a matching ALU write is NOT squashed; the slow result is program-order newer.
- pend_mask: combinational OR over live entries of (1<<rd); bit 0 is always 0.
- Counts:
  - fifo_count is +1 on enqueue, -1 on pop, unchanged on simultaneous enqueue and pop.
  - Never exceeds DEPTH and never underflows.
- Among FIFO entries, writes occur in strict arrival order.
- No combinational path from the slow_* inputs to slow_ready.

Test Plan:
- Reset: hold rst=0 with random inputs -> wb_we=0, wb_rd=0, wb_data=0, slow_ready=1, pend_mask=0, fifo_count=0; release, then alu x5=0x1234 -> one cycle later we=1, rd=5, data=0x1234.
- Drain: slow x7=0xAAAA accepted with the ALU idle -> pend_mask=0x80, fifo_count=1; next edge we=1, rd=7, data=0xAAAA; pend_mask=0.
- Full FIFO: ALU busy (x1..x4) for 6 cycles while slow offers x8..x11 then x12 -> x8..x11 accepted, x12 stalled (slow_ready=0, fifo_count=4); when the ALU goes idle, writes x8, x9, x10, x11 in order and x12 is accepted after the first pop.
- Squash: FIFO holds x9=0x1; ALU writes x9=0x2 -> port writes x9=0x2; the later drain emits a bubble (we=0); final x9=0x2; pend_mask bit 9 clears at the ALU edge.
- Same-edge: enqueue x3=0xB on the edge the ALU writes x3=0xA -> writes x3=0xA, then x3=0xB.
- x0: ALU rd=0 with the FIFO holding x4 -> the x4 drain proceeds; slow rd=0 is accepted, fifo_count is unchanged and no write occurs.
- Async reset with 3 entries queued: rst pulled low mid-cycle -> outputs clear immediately; no further writes.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 32x32 register file.
// Merges the single-cycle ALU result stream with a FIFO-buffered slow path
// (loads, multi-cycle units) onto one registered write port.
// ALU results always win the port. Queued slow results that target the
// same register as an ALU write are squashed, so stale data never lands.
// pend_mask tells hazard logic which destinations still have a live result queued.
module regfile_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     slow_valid,
    output logic                     slow_ready,
    input  logic [4:0]               slow_rd,
    input  logic [XLEN-1:0]          slow_data,
    output logic                     wb_we,
    output logic [4:0]               wb_rd,
    output logic [XLEN-1:0]          wb_data,
    output logic [31:0]              pend_mask,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // FIFO storage: destination, data and a live bit per entry.
    logic [4:0]       ent_rd_q   [DEPTH];
    logic [XLEN-1:0]  ent_data_q [DEPTH];
    logic [DEPTH-1:0] ent_live_q;
    logic [DEPTH-1:0] ent_live_d;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;

    logic             wb_we_q, wb_we_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]  wb_data_q, wb_data_d;

    logic             alu_eff;
    logic             slow_accept;
    logic             enq;
    logic             pop;
    logic             head_live;

    // Slow-path handshake: a transfer happens on a rising edge where
    // slow_valid && slow_ready are both high. slow_ready depends on registered
    // occupancy only, so a full FIFO never accepts in the same cycle it pops.
    // The producer must hold slow_rd/slow_data stable while slow_valid is high
    // and slow_ready is low.
    assign slow_ready  = (count_q < CW'(DEPTH));
    assign slow_accept = slow_valid && slow_ready;

    // Writes to x0 are dropped at the source on both paths.
    assign alu_eff   = alu_valid && (alu_rd != 5'd0);
    assign enq       = slow_accept && (slow_rd != 5'd0);
    assign pop       = !alu_eff && (count_q != '0);
    assign head_live = ent_live_q[rd_ptr_q];

    assign wb_we      = wb_we_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign fifo_count = count_q;

    // Live-bit update: squash older matching entries, retire the head, mark the new tail.
    always_comb begin
        ent_live_d = ent_live_q;
        if (alu_eff) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_rd_q[i] == alu_rd) ent_live_d[i] = 1'b0;
            end
        end
        if (pop) ent_live_d[rd_ptr_q] = 1'b0;
        // The entry written on this edge is newer than the ALU result, so it stays live.
        if (enq) ent_live_d[wr_ptr_q] = 1'b1;
    end

    // Occupancy counts squashed entries too; they still have to drain as bubbles.
    always_comb begin
        count_d = count_q;
        case ({enq, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Port selection: ALU first, then the FIFO head, otherwise idle with rd/data held.
    always_comb begin
        wb_we_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        if (alu_eff) begin
            wb_we_d   = 1'b1;
            wb_rd_d   = alu_rd;
            wb_data_d = alu_data;
        end else if (pop) begin
            wb_we_d = head_live;
            if (head_live) begin
                wb_rd_d   = ent_rd_q[rd_ptr_q];
                wb_data_d = ent_data_q[rd_ptr_q];
            end
        end
    end

    // Pending destinations: one bit per live queued entry.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_live_q[i]) pend_mask[ent_rd_q[i]] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd_q[i]   <= '0;
                ent_data_q[i] <= '0;
            end
            ent_live_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if (enq) begin
                ent_rd_q[wr_ptr_q]   <= slow_rd;
                ent_data_q[wr_ptr_q] <= slow_data;
                wr_ptr_q             <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            ent_live_q <= ent_live_d;
            count_q    <= count_d;
        end
    end

    // Registered write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_we_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            wb_we_q   <= wb_we_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with constant expectations
// plus a randomized run against a queue-based reference model.
module tb_regfile_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic                   clk;
    logic                   rst;
    logic                   alu_valid;
    logic [4:0]             alu_rd;
    logic [XLEN-1:0]        alu_data;
    logic                   slow_valid;
    logic                   slow_ready;
    logic [4:0]             slow_rd;
    logic [XLEN-1:0]        slow_data;
    logic                   wb_we;
    logic [4:0]             wb_rd;
    logic [XLEN-1:0]        wb_data;
    logic [31:0]            pend_mask;
    logic [$clog2(DEPTH):0] fifo_count;

    regfile_wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .slow_valid (slow_valid),
        .slow_ready (slow_ready),
        .slow_rd    (slow_rd),
        .slow_data  (slow_data),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .pend_mask  (pend_mask),
        .fifo_count (fifo_count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of pending slow results in arrival order.
    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic            live;
    } ent_t;

    ent_t            mq[$];
    logic            m_we;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_data;
    logic            m_acc;
    logic [XLEN-1:0] model_rf [32];
    logic [XLEN-1:0] dut_rf   [32];
    logic [36:0]     exp_q[$];
    logic [36:0]     got_q[$];

    int vec_cnt = 0;
    int err_cnt = 0;

    function automatic logic [31:0] m_mask();
        logic [31:0] m;
        m = '0;
        foreach (mq[i]) if (mq[i].live) m = m | (32'd1 << mq[i].rd);
        return m;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_we   = 1'b0;
        m_rd   = '0;
        m_data = '0;
    endtask

    // Drive one cycle of inputs, advance the model, then wait past the edge.
    task automatic step(input logic av, input logic [4:0] ar, input logic [XLEN-1:0] ad,
                        input logic sv, input logic [4:0] sr, input logic [XLEN-1:0] sd);
        ent_t e;
        alu_valid  = av;
        alu_rd     = ar;
        alu_data   = ad;
        slow_valid = sv;
        slow_rd    = sr;
        slow_data  = sd;
        m_acc = sv && (mq.size() < DEPTH);
        if (av && ar != 5'd0) begin
            m_we   = 1'b1;
            m_rd   = ar;
            m_data = ad;
            foreach (mq[i]) if (mq[i].rd == ar) mq[i].live = 1'b0;
        end else if (mq.size() > 0) begin
            e    = mq.pop_front();
            m_we = e.live;
            if (e.live) begin
                m_rd   = e.rd;
                m_data = e.data;
            end
        end else begin
            m_we = 1'b0;
        end
        if (m_we) model_rf[m_rd] = m_data;
        if (m_acc && sr != 5'd0) begin
            e.rd   = sr;
            e.data = sd;
            e.live = 1'b1;
            mq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (wb_we) dut_rf[wb_rd] = wb_data;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            alu_valid  = 1'($urandom_range(0, 1));
            alu_rd     = 5'($urandom_range(0, 31));
            alu_data   = $urandom;
            slow_valid = 1'($urandom_range(0, 1));
            slow_rd    = 5'($urandom_range(0, 31));
            slow_data  = $urandom;
            @(posedge clk);
            #1;
            vec_cnt++; if (wb_we !== 1'b0) begin err_cnt++; $display("FAIL reset_we: got %0b want 0", wb_we); end
            vec_cnt++; if (wb_rd !== 5'd0) begin err_cnt++; $display("FAIL reset_rd: got %0d want 0", wb_rd); end
            vec_cnt++; if (wb_data !== 32'd0) begin err_cnt++; $display("FAIL reset_data: got %h want 0", wb_data); end
            vec_cnt++; if (slow_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_ready: got %0b want 1", slow_ready); end
            vec_cnt++; if (pend_mask !== 32'd0) begin err_cnt++; $display("FAIL reset_mask: got %h want 0", pend_mask); end
            vec_cnt++; if (fifo_count !== 3'd0) begin err_cnt++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        end
        model_reset();
        for (int r = 0; r < 32; r++) begin
            model_rf[r] = '0;
            dut_rf[r]   = '0;
        end
        rst = 1'b1;
        step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, '0);
        vec_cnt++; if (wb_we !== 1'b1) begin err_cnt++; $display("FAIL alu_first_we: got %0b want 1", wb_we); end
        vec_cnt++; if (wb_rd !== 5'd5) begin err_cnt++; $display("FAIL alu_first_rd: got %0d want 5", wb_rd); end
        vec_cnt++; if (wb_data !== 32'h1234) begin err_cnt++; $display("FAIL alu_first_data: got %h want 1234", wb_data); end
    endtask

    task automatic test_drain();
        step(1'b0, 5'd0, '0, 1'b1, 5'd7, 32'hAAAA);
        vec_cnt++; if (pend_mask !== 32'h80) begin err_cnt++; $display("FAIL drain_mask_set: got %h want 80", pend_mask); end
        vec_cnt++; if (fifo_count !== 3'd1) begin err_cnt++; $display("FAIL drain_count: got %0d want 1", fifo_count); end
        vec_cnt++; if (wb_we !== 1'b0) begin err_cnt++; $display("FAIL drain_no_early_write: got %0b want 0", wb_we); end
        idle();
        vec_cnt++; if (wb_we !== 1'b1) begin err_cnt++; $display("FAIL drain_we: got %0b want 1", wb_we); end
        vec_cnt++; if (wb_rd !== 5'd7) begin err_cnt++; $display("FAIL drain_rd: got %0d want 7", wb_rd); end
        vec_cnt++; if (wb_data !== 32'hAAAA) begin err_cnt++; $display("FAIL drain_data: got %h want AAAA", wb_data); end
        vec_cnt++; if (pend_mask !== 32'd0) begin err_cnt++; $display("FAIL drain_mask_clear: got %h want 0", pend_mask); end
    endtask

    task automatic test_full();
        logic [4:0]      src_rd [5];
        logic [XLEN-1:0] src_d  [5];
        int              idx;
        logic            rdy;
        idx = 0;
        exp_q.delete();
        got_q.delete();
        for (int k = 0; k < 5; k++) begin
            src_rd[k] = 5'(8 + k);
            src_d[k]  = $urandom;
            exp_q.push_back({src_rd[k], src_d[k]});
        end
        for (int c = 0; c < 6; c++) begin
            rdy = slow_ready;
            vec_cnt++;
            if (rdy !== (c < 4)) begin err_cnt++; $display("FAIL full_ready_c%0d: got %0b want %0b", c, rdy, (c < 4)); end
            step(1'b1, 5'(1 + c % 4), $urandom, idx < 5, src_rd[idx < 5 ? idx : 4], src_d[idx < 5 ? idx : 4]);
            if (rdy && idx < 5) idx++;
        end
        vec_cnt++; if (fifo_count !== 3'd4) begin err_cnt++; $display("FAIL full_count: got %0d want 4", fifo_count); end
        vec_cnt++; if (slow_ready !== 1'b0) begin err_cnt++; $display("FAIL full_stall: got %0b want 0", slow_ready); end
        for (int c = 0; c < 8; c++) begin
            rdy = slow_ready;
            if (c == 1) begin
                vec_cnt++; if (rdy !== 1'b1) begin err_cnt++; $display("FAIL full_accept_after_pop: got %0b want 1", rdy); end
            end
            step(1'b0, 5'd0, '0, idx < 5, src_rd[idx < 5 ? idx : 4], src_d[idx < 5 ? idx : 4]);
            if (rdy && idx < 5) idx++;
            if (wb_we) got_q.push_back({wb_rd, wb_data});
        end
        vec_cnt++;
        if (got_q.size() != 5) begin err_cnt++; $display("FAIL full_write_count: got %0d want 5", got_q.size()); end
        for (int k = 0; k < 5 && k < got_q.size(); k++) begin
            vec_cnt++;
            if (got_q[k] !== exp_q[k]) begin
                err_cnt++;
                $display("FAIL full_order_%0d: got x%0d=%h want x%0d=%h", k, got_q[k][36:32], got_q[k][31:0], exp_q[k][36:32], exp_q[k][31:0]);
            end
        end
    endtask

    task automatic test_squash();
        step(1'b1, 5'd20, $urandom, 1'b1, 5'd9, 32'h1);
        vec_cnt++; if (pend_mask[9] !== 1'b1) begin err_cnt++; $display("FAIL squash_pend_set: got %0b want 1", pend_mask[9]); end
        step(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, '0);
        vec_cnt++; if (wb_we !== 1'b1 || wb_rd !== 5'd9 || wb_data !== 32'h2) begin
            err_cnt++; $display("FAIL squash_alu_write: got we=%0b x%0d=%h want we=1 x9=2", wb_we, wb_rd, wb_data); end
        vec_cnt++; if (pend_mask[9] !== 1'b0) begin err_cnt++; $display("FAIL squash_pend_clear: got %0b want 0", pend_mask[9]); end
        vec_cnt++; if (fifo_count !== 3'd1) begin err_cnt++; $display("FAIL squash_count_held: got %0d want 1", fifo_count); end
        idle();
        vec_cnt++; if (wb_we !== 1'b0) begin err_cnt++; $display("FAIL squash_bubble: got %0b want 0", wb_we); end
        vec_cnt++; if (fifo_count !== 3'd0) begin err_cnt++; $display("FAIL squash_count_drained: got %0d want 0", fifo_count); end
        idle();
        vec_cnt++; if (dut_rf[9] !== 32'h2) begin err_cnt++; $display("FAIL squash_final_x9: got %h want 2", dut_rf[9]); end
    endtask

    task automatic test_same_edge();
        step(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB);
        vec_cnt++; if (wb_we !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'hA) begin
            err_cnt++; $display("FAIL same_edge_alu: got we=%0b x%0d=%h want we=1 x3=a", wb_we, wb_rd, wb_data); end
        vec_cnt++; if (pend_mask !== 32'h8) begin err_cnt++; $display("FAIL same_edge_mask: got %h want 8", pend_mask); end
        idle();
        vec_cnt++; if (wb_we !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'hB) begin
            err_cnt++; $display("FAIL same_edge_slow: got we=%0b x%0d=%h want we=1 x3=b", wb_we, wb_rd, wb_data); end
        vec_cnt++; if (dut_rf[3] !== 32'hB) begin err_cnt++; $display("FAIL same_edge_final_x3: got %h want b", dut_rf[3]); end
    endtask

    task automatic test_x0();
        step(1'b1, 5'd1, $urandom, 1'b1, 5'd4, 32'h44);
        vec_cnt++; if (fifo_count !== 3'd1) begin err_cnt++; $display("FAIL x0_count_before: got %0d want 1", fifo_count); end
        vec_cnt++; if (slow_ready !== 1'b1) begin err_cnt++; $display("FAIL x0_ready: got %0b want 1", slow_ready); end
        step(1'b1, 5'd0, 32'h77, 1'b1, 5'd0, 32'h99);
        vec_cnt++; if (wb_we !== 1'b1 || wb_rd !== 5'd4 || wb_data !== 32'h44) begin
            err_cnt++; $display("FAIL x0_drain: got we=%0b x%0d=%h want we=1 x4=44", wb_we, wb_rd, wb_data); end
        vec_cnt++; if (fifo_count !== 3'd0) begin err_cnt++; $display("FAIL x0_no_enqueue: got %0d want 0", fifo_count); end
        idle();
        vec_cnt++; if (wb_we !== 1'b0) begin err_cnt++; $display("FAIL x0_no_write: got %0b want 0", wb_we); end
        vec_cnt++; if (pend_mask !== 32'd0) begin err_cnt++; $display("FAIL x0_mask: got %h want 0", pend_mask); end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 3; c++) step(1'b1, 5'(1 + c), 32'hC0DE_0000 | c, 1'b1, 5'(10 + c), $urandom);
        vec_cnt++; if (fifo_count !== 3'd3) begin err_cnt++; $display("FAIL areset_count_before: got %0d want 3", fifo_count); end
        alu_valid  = 1'b0;
        slow_valid = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        vec_cnt++; if (wb_we !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin
            err_cnt++; $display("FAIL areset_port: got we=%0b x%0d=%h want all 0", wb_we, wb_rd, wb_data); end
        vec_cnt++; if (fifo_count !== 3'd0 || pend_mask !== 32'd0 || slow_ready !== 1'b1) begin
            err_cnt++; $display("FAIL areset_fifo: got count=%0d mask=%h ready=%0b want 0 0 1", fifo_count, pend_mask, slow_ready); end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            idle();
            vec_cnt++; if (wb_we !== 1'b0) begin err_cnt++; $display("FAIL areset_no_write_%0d: got %0b want 0", c, wb_we); end
        end
    endtask

    task automatic test_random();
        logic            av, sv;
        logic [4:0]      ar, sr;
        for (int c = 0; c < 400; c++) begin
            vec_cnt++; if (slow_ready !== (mq.size() < DEPTH)) begin
                err_cnt++; $display("FAIL rand_ready_c%0d: got %0b want %0b", c, slow_ready, (mq.size() < DEPTH)); end
            vec_cnt++; if (pend_mask !== m_mask()) begin
                err_cnt++; $display("FAIL rand_mask_c%0d: got %h want %h", c, pend_mask, m_mask()); end
            vec_cnt++; if (fifo_count !== mq.size()) begin
                err_cnt++; $display("FAIL rand_count_c%0d: got %0d want %0d", c, fifo_count, mq.size()); end
            av = ($urandom_range(0, 99) < 50);
            ar = 5'($urandom_range(0, 7));
            sv = ($urandom_range(0, 99) < 70);
            sr = 5'($urandom_range(0, 7));
            step(av, ar, $urandom, sv, sr, $urandom);
            vec_cnt++; if (wb_we !== m_we || wb_rd !== m_rd || wb_data !== m_data) begin
                err_cnt++; $display("FAIL rand_port_c%0d: got we=%0b x%0d=%h want we=%0b x%0d=%h", c, wb_we, wb_rd, wb_data, m_we, m_rd, m_data); end
        end
        for (int c = 0; c < 2 * DEPTH; c++) idle();
        for (int r = 0; r < 32; r++) begin
            vec_cnt++; if (dut_rf[r] !== model_rf[r]) begin
                err_cnt++; $display("FAIL rand_rf_x%0d: got %h want %h", r, dut_rf[r], model_rf[r]); end
        end
    endtask

    initial begin
        rst        = 1'b0;
        alu_valid  = 1'b0;
        alu_rd     = '0;
        alu_data   = '0;
        slow_valid = 1'b0;
        slow_rd    = '0;
        slow_data  = '0;
        test_reset();
        test_drain();
        test_full();
        test_squash();
        test_same_edge();
        test_x0();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
